// File: rtl/mmu_pkg.sv
// Shared MMU types for the L2 TLB request path.
//   PTE_T            : leaf page-table entry as returned by the walker
//   tlb_info_t       : requester tag {source, idx} echoed with every response
//   tlb_req_entry_t  : one miss-queue entry {addr, info}
//   SRC_*            : encodings of tlb_info_t.source
package mmu_pkg;

  localparam int MMU_VADDR_SIZE = 39;
  localparam int MMU_IDX_WIDTH  = 5;
  localparam int PTE_WIDTH      = 64;

  typedef logic [PTE_WIDTH-1:0] PTE_T;

  localparam logic [1:0] SRC_IFETCH = 2'b00;
  localparam logic [1:0] SRC_LOAD   = 2'b01;
  localparam logic [1:0] SRC_STORE  = 2'b10;
  localparam logic [1:0] SRC_AMO    = 2'b11;

  typedef struct packed {
    logic [1:0]               source;
    logic [MMU_IDX_WIDTH-1:0] idx;
  } tlb_info_t;

  typedef struct packed {
    logic [MMU_VADDR_SIZE-1:0] addr;
    tlb_info_t                 info;
  } tlb_req_entry_t;

  function automatic tlb_req_entry_t make_entry(
    input logic [MMU_VADDR_SIZE-1:0] addr,
    input logic [1:0]                source,
    input logic [MMU_IDX_WIDTH-1:0]  idx
  );
    tlb_req_entry_t e;
    e.addr        = addr;
    e.info.source = source;
    e.info.idx    = idx;
    return e;
  endfunction

endpackage

// File: rtl/l2_tlb_miss_fifo.sv
// In-order circular miss queue with head/tail pointers and an occupancy count.
//   clk, rst           : clock, async active-high reset
//   push_i/push_data_i : write an entry at the tail (caller guarantees !full_o)
//   pop_i              : retire the head entry
//   flush_i            : discard queued entries
//   flush_keep_head_i  : on flush, keep the head entry (it is being walked)
//   full_o, empty_o    : occupancy flags for the current cycle
//   head_data_o        : entry at the head pointer
module l2_tlb_miss_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic             flush_keep_head_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_data_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign head_data_o = mem_q[head_q];

  // Payload storage needs no reset: the count qualifies every read.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[tail_q] <= push_data_i;
  end

  // A flush leaves at most the in-flight head entry. If that entry is popped
  // in the same cycle the queue ends empty with tail == new head.
  always_comb begin
    head_d = head_q + PTR_W'(pop_i);
    if (flush_i) begin
      tail_d  = head_q + PTR_W'(flush_keep_head_i);
      count_d = (flush_keep_head_i && !pop_i) ? CNT_W'(1) : '0;
    end else begin
      tail_d  = tail_q + PTR_W'(push_i);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/l2_tlb_req_queue.sv
// L2 TLB request responder: buffers first-level TLB misses, serializes them
// onto one page-table-walker port and returns one registered response per
// request. Requests arriving to a full queue get an error response.
//   clk, rst, flush                       : clock, async reset, discard all
//   req, req_addr, req_source, req_idx    : miss request pulse and payload
//   walk_req, walk_vaddr, walk_ready      : walker request handshake
//   walk_resp_valid, walk_entry, walk_wpn,
//   walk_error, walk_exception            : walker result (one cycle)
//   dataValid, info_o_source, info_o_idx,
//   entry, wpn, waddr, error, exception   : registered response
//
// state | meaning
// IDLE  | offering the queue head to the walker
// WALK  | head accepted by walker, waiting for its result
module l2_tlb_req_queue
  import mmu_pkg::*;
#(
  parameter int VADDR_SIZE = MMU_VADDR_SIZE,
  parameter int TLB_OFFSET = 12,
  parameter int IDX_WIDTH  = MMU_IDX_WIDTH,
  parameter int WPN_WIDTH  = 2,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req,
  input  logic [VADDR_SIZE-1:0] req_addr,
  input  logic [1:0]            req_source,
  input  logic [IDX_WIDTH-1:0]  req_idx,
  output logic                  walk_req,
  output logic [VADDR_SIZE-1:0] walk_vaddr,
  input  logic                  walk_ready,
  input  logic                  walk_resp_valid,
  input  PTE_T                  walk_entry,
  input  logic [WPN_WIDTH-1:0]  walk_wpn,
  input  logic                  walk_error,
  input  logic                  walk_exception,
  output logic                  dataValid,
  output logic [1:0]            info_o_source,
  output logic [IDX_WIDTH-1:0]  info_o_idx,
  output PTE_T                  entry,
  output logic [WPN_WIDTH-1:0]  wpn,
  output logic [VADDR_SIZE-1:0] waddr,
  output logic                  error,
  output logic                  exception
);

  // Queue entries use the package struct, so the widths must agree with it.
  if (VADDR_SIZE != MMU_VADDR_SIZE || IDX_WIDTH != MMU_IDX_WIDTH) begin : g_bad_width
    $error("l2_tlb_req_queue: VADDR_SIZE/IDX_WIDTH must match mmu_pkg");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("l2_tlb_req_queue: DEPTH must be a power of two >= 2");
  end
  if (TLB_OFFSET >= VADDR_SIZE) begin : g_bad_offset
    $error("l2_tlb_req_queue: TLB_OFFSET must be below VADDR_SIZE");
  end

  localparam int ENTRY_W = $bits(tlb_req_entry_t);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WALK = 1'b1;

  logic [0:0]     state_q, state_d;
  logic           killed_q, killed_d;
  logic           rej_v_q, rej_v_d;
  tlb_req_entry_t rej_q, rej_d;

  logic                 rsp_valid_q, rsp_valid_d;
  tlb_info_t            rsp_info_q, rsp_info_d;
  PTE_T                 rsp_entry_q, rsp_entry_d;
  logic [WPN_WIDTH-1:0] rsp_wpn_q, rsp_wpn_d;
  logic [VADDR_SIZE-1:0] rsp_addr_q, rsp_addr_d;
  logic                 rsp_error_q, rsp_error_d;
  logic                 rsp_exc_q, rsp_exc_d;

  logic           fifo_full, fifo_empty;
  tlb_req_entry_t head_entry, new_entry, rej_src;
  logic           in_walk, push, refuse, walk_done;

  assign in_walk   = (state_q == ST_WALK);
  assign push      = req && !flush && !fifo_full;
  assign refuse    = req && !flush && fifo_full;
  // Results arriving while IDLE (e.g. after a reset mid-walk) are ignored.
  assign walk_done = in_walk && walk_resp_valid;
  assign new_entry = make_entry(req_addr, req_source, req_idx);

  assign walk_req   = !in_walk && !fifo_empty && !flush;
  assign walk_vaddr = walk_req ? head_entry.addr : '0;

  l2_tlb_miss_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk               (clk),
    .rst               (rst),
    .push_i            (push),
    .push_data_i       (new_entry),
    .pop_i             (walk_done),
    .flush_i           (flush),
    .flush_keep_head_i (in_walk),
    .full_o            (fifo_full),
    .empty_o           (fifo_empty),
    .head_data_o       (head_entry)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (walk_req && walk_ready) state_d = ST_WALK;
      ST_WALK: if (walk_resp_valid)        state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A walk in flight at flush time still has to be consumed; killed marks
  // that its result must not be reported.
  always_comb begin
    killed_d = killed_q;
    if (walk_done)              killed_d = 1'b0;
    else if (flush && in_walk)  killed_d = 1'b1;
  end

  // Walk results win the response port. A refusal that collides with one is
  // parked in rej_q for the next cycle; otherwise it is answered directly.
  // A flush discards any response for the cycle along with a parked refusal.
  always_comb begin
    rsp_valid_d = 1'b0;
    rsp_info_d  = rsp_info_q;
    rsp_entry_d = rsp_entry_q;
    rsp_wpn_d   = rsp_wpn_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_error_d = rsp_error_q;
    rsp_exc_d   = rsp_exc_q;
    rej_v_d     = rej_v_q;
    rej_d       = rej_q;
    rej_src     = rej_v_q ? rej_q : new_entry;

    if (walk_done) begin
      if (!killed_q && !flush) begin
        rsp_valid_d = 1'b1;
        rsp_info_d  = head_entry.info;
        rsp_addr_d  = head_entry.addr;
        rsp_entry_d = walk_entry;
        rsp_wpn_d   = walk_wpn;
        rsp_error_d = walk_error;
        rsp_exc_d   = walk_exception;
      end
      if (refuse) begin
        rej_v_d = 1'b1;
        rej_d   = new_entry;
      end
    end else if (!flush && (rej_v_q || refuse)) begin
      rsp_valid_d = 1'b1;
      rsp_info_d  = rej_src.info;
      rsp_addr_d  = rej_src.addr;
      rsp_entry_d = '0;
      rsp_wpn_d   = '0;
      rsp_error_d = 1'b1;
      rsp_exc_d   = 1'b0;
      rej_v_d     = rej_v_q && refuse;
      rej_d       = new_entry;
    end

    if (flush) rej_v_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      killed_q    <= 1'b0;
      rej_v_q     <= 1'b0;
      rej_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_info_q  <= '0;
      rsp_entry_q <= '0;
      rsp_wpn_q   <= '0;
      rsp_addr_q  <= '0;
      rsp_error_q <= 1'b0;
      rsp_exc_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      killed_q    <= killed_d;
      rej_v_q     <= rej_v_d;
      rej_q       <= rej_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_info_q  <= rsp_info_d;
      rsp_entry_q <= rsp_entry_d;
      rsp_wpn_q   <= rsp_wpn_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_error_q <= rsp_error_d;
      rsp_exc_q   <= rsp_exc_d;
    end
  end

  // A parked refusal only exists after a walk pop freed a slot, and the
  // walker cannot pop twice in a row, so a second refusal cannot collide.
  assert property (@(posedge clk) disable iff (rst) !(refuse && rej_v_q && walk_done));

  assign dataValid     = rsp_valid_q;
  assign info_o_source = rsp_info_q.source;
  assign info_o_idx    = rsp_info_q.idx;
  assign entry         = rsp_entry_q;
  assign wpn           = rsp_wpn_q;
  assign waddr         = rsp_addr_q;
  assign error         = rsp_error_q;
  assign exception     = rsp_exc_q;

endmodule

// File: tb/tb_l2_tlb_req_queue.sv
module tb_l2_tlb_req_queue;
  import mmu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, req;
  logic [38:0] req_addr;
  logic [1:0]  req_source;
  logic [4:0]  req_idx;
  logic        walk_req;
  logic [38:0] walk_vaddr;
  logic        walk_ready, walk_resp_valid;
  PTE_T        walk_entry;
  logic [1:0]  walk_wpn;
  logic        walk_error, walk_exception;
  logic        dataValid;
  logic [1:0]  info_o_source;
  logic [4:0]  info_o_idx;
  PTE_T        entry;
  logic [1:0]  wpn;
  logic [38:0] waddr;
  logic        error, exception;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l2_tlb_req_queue dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .req             (req),
    .req_addr        (req_addr),
    .req_source      (req_source),
    .req_idx         (req_idx),
    .walk_req        (walk_req),
    .walk_vaddr      (walk_vaddr),
    .walk_ready      (walk_ready),
    .walk_resp_valid (walk_resp_valid),
    .walk_entry      (walk_entry),
    .walk_wpn        (walk_wpn),
    .walk_error      (walk_error),
    .walk_exception  (walk_exception),
    .dataValid       (dataValid),
    .info_o_source   (info_o_source),
    .info_o_idx      (info_o_idx),
    .entry           (entry),
    .wpn             (wpn),
    .waddr           (waddr),
    .error           (error),
    .exception       (exception)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [38:0] a, input logic [1:0] s, input logic [4:0] i);
    req = 1'b1; req_addr = a; req_source = s; req_idx = i;
  endtask

  // Issue the head to the walker, answer one cycle later, check the response.
  task automatic walk_one(input string tag, input logic [38:0] va, input logic [1:0] src,
                          input logic [4:0] idx, input logic [63:0] pte, input logic [1:0] lvl,
                          input logic err, input logic exc);
    walk_ready = 1'b1;
    #1;
    chk({tag, ".walk_req"}, walk_req, 1);
    chk({tag, ".walk_vaddr"}, walk_vaddr, va);
    tick();
    walk_ready = 1'b0;
    chk({tag, ".walk_req_in_walk"}, walk_req, 0);
    walk_resp_valid = 1'b1; walk_entry = pte; walk_wpn = lvl;
    walk_error = err; walk_exception = exc;
    tick();
    walk_resp_valid = 1'b0; walk_entry = '0; walk_wpn = '0;
    walk_error = 1'b0; walk_exception = 1'b0;
    chk({tag, ".dataValid"}, dataValid, 1);
    chk({tag, ".source"}, info_o_source, src);
    chk({tag, ".idx"}, info_o_idx, idx);
    chk({tag, ".waddr"}, waddr, va);
    chk({tag, ".entry"}, entry, pte);
    chk({tag, ".wpn"}, wpn, lvl);
    chk({tag, ".error"}, error, err);
    chk({tag, ".exception"}, exception, exc);
  endtask

  initial begin
    logic [38:0] a;
    rst = 1'b1; flush = 1'b0; req = 1'b0; req_addr = '0; req_source = '0; req_idx = '0;
    walk_ready = 1'b0; walk_resp_valid = 1'b0; walk_entry = '0; walk_wpn = '0;
    walk_error = 1'b0; walk_exception = 1'b0;
    #2;
    chk("reset.dataValid", dataValid, 0);
    chk("reset.walk_req", walk_req, 0);
    chk("reset.walk_vaddr", walk_vaddr, 0);
    chk("reset.error", error, 0);
    chk("reset.waddr", waddr, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single load miss, walker answers 3 cycles after issue.
    walk_ready = 1'b1;
    send(39'h0_8000_1234, SRC_LOAD, 5'd5);
    #1 chk("t1.walk_req_same_cycle", walk_req, 0);
    tick();
    req = 1'b0;
    chk("t1.walk_req", walk_req, 1);
    chk("t1.walk_vaddr", walk_vaddr, 39'h0_8000_1234);
    tick();
    chk("t1.walk_req_in_walk", walk_req, 0);
    tick(); tick();
    chk("t1.no_early_resp", dataValid, 0);
    walk_resp_valid = 1'b1; walk_entry = 64'h0000_0000_2000_04CF; walk_wpn = 2'd0;
    tick();
    walk_resp_valid = 1'b0; walk_entry = '0; walk_ready = 1'b0;
    chk("t1.dataValid", dataValid, 1);
    chk("t1.source", info_o_source, 2'b01);
    chk("t1.idx", info_o_idx, 5);
    chk("t1.waddr", waddr, 39'h0_8000_1234);
    chk("t1.entry", entry, 64'h0000_0000_2000_04CF);
    chk("t1.error", error, 0);
    tick();
    chk("t1.pulse", dataValid, 0);

    // Fill DEPTH+1 with the walker stalled; the fifth is refused.
    for (int i = 0; i < 5; i++) begin
      a = 39'(i + 1) << 12;
      send(a, (i % 2 == 0) ? SRC_LOAD : SRC_STORE, 5'(10 + i));
      #1 chk("t2.walk_req_fill", walk_req, (i != 0) ? 1 : 0);
      tick();
    end
    req = 1'b0;
    chk("t2.rej_dataValid", dataValid, 1);
    chk("t2.rej_error", error, 1);
    chk("t2.rej_exception", exception, 0);
    chk("t2.rej_idx", info_o_idx, 14);
    chk("t2.rej_source", info_o_source, SRC_LOAD);
    chk("t2.rej_waddr", waddr, 39'h5000);
    chk("t2.rej_entry", entry, 0);
    for (int i = 0; i < 4; i++)
      walk_one("t2.walk", 39'(i + 1) << 12, (i % 2 == 0) ? SRC_LOAD : SRC_STORE, 5'(10 + i),
               64'h100 + 64'(i), 2'(i), 1'b0, 1'b0);
    tick();
    chk("t2.drained", walk_req, 0);

    // Walk response and refusal in the same cycle.
    for (int i = 0; i < 4; i++) begin
      send(39'h2_0000 + (39'(i) << 12), SRC_AMO, 5'(20 + i));
      tick();
    end
    req = 1'b0;
    walk_ready = 1'b1;
    tick();
    walk_ready = 1'b0;
    walk_resp_valid = 1'b1; walk_entry = 64'hAA; walk_wpn = 2'd1;
    send(39'h3_0000, SRC_LOAD, 5'd24);
    tick();
    walk_resp_valid = 1'b0; walk_entry = '0; walk_wpn = '0;
    send(39'h3_1000, SRC_STORE, 5'd25);
    chk("t3.walk_rsp_valid", dataValid, 1);
    chk("t3.walk_rsp_idx", info_o_idx, 20);
    chk("t3.walk_rsp_error", error, 0);
    chk("t3.walk_rsp_entry", entry, 64'hAA);
    tick();
    req = 1'b0;
    chk("t3.rej_valid", dataValid, 1);
    chk("t3.rej_error", error, 1);
    chk("t3.rej_idx", info_o_idx, 24);
    chk("t3.rej_waddr", waddr, 39'h3_0000);
    tick();
    chk("t3.pulse", dataValid, 0);
    for (int i = 1; i < 4; i++)
      walk_one("t3.walk", 39'h2_0000 + (39'(i) << 12), SRC_AMO, 5'(20 + i),
               64'h200 + 64'(i), 2'd2, 1'b0, 1'b0);
    walk_one("t3.freed_slot", 39'h3_1000, SRC_STORE, 5'd25, 64'h300, 2'd3, 1'b1, 1'b0);
    tick();
    chk("t3.drained", walk_req, 0);

    // Flush while walking with three entries queued.
    for (int i = 0; i < 3; i++) begin
      send(39'hA000 + (39'(i) << 12), SRC_LOAD, 5'(1 + i));
      tick();
    end
    req = 1'b0;
    walk_ready = 1'b1;
    tick();
    walk_ready = 1'b0;
    flush = 1'b1;
    send(39'hEEE000, SRC_LOAD, 5'd31);
    tick();
    flush = 1'b0; req = 1'b0;
    chk("t4.walk_req_after_flush", walk_req, 0);
    walk_resp_valid = 1'b1; walk_entry = 64'h55;
    tick();
    walk_resp_valid = 1'b0; walk_entry = '0;
    chk("t4.killed_no_dataValid", dataValid, 0);
    chk("t4.empty_after_pop", walk_req, 0);
    send(39'hB000, SRC_IFETCH, 5'd7);
    tick();
    req = 1'b0;
    chk("t4.killed_still_quiet", dataValid, 0);
    walk_one("t4.post_flush", 39'hB000, SRC_IFETCH, 5'd7, 64'h77, 2'd1, 1'b0, 1'b0);
    tick();
    chk("t4.dropped_req_absent", walk_req, 0);

    // 2*DEPTH sequential misses (pointer wrap) with one page fault.
    for (int k = 0; k < 8; k++) begin
      a = 39'hC000 + (39'(k) << 12);
      send(a, SRC_STORE, 5'(k));
      tick();
      req = 1'b0;
      walk_one("t5.seq", a, SRC_STORE, 5'(k), 64'h1000 + 64'(k), 2'(k % 3), 1'b0, k == 3);
    end

    // Async reset during a walk.
    send(39'hD000, SRC_AMO, 5'd9);
    tick();
    req = 1'b0;
    walk_ready = 1'b1;
    tick();
    walk_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6.rst_dataValid", dataValid, 0);
    chk("t6.rst_walk_req", walk_req, 0);
    chk("t6.rst_walk_vaddr", walk_vaddr, 0);
    chk("t6.rst_waddr", waddr, 0);
    chk("t6.rst_entry", entry, 0);
    chk("t6.rst_idx", info_o_idx, 0);
    chk("t6.rst_wpn", wpn, 0);
    tick(); tick();
    rst = 1'b0;
    walk_resp_valid = 1'b1; walk_entry = 64'h99;
    tick();
    walk_resp_valid = 1'b0; walk_entry = '0;
    chk("t6.stray_resp", dataValid, 0);
    tick();
    chk("t6.stray_resp_late", dataValid, 0);
    chk("t6.queue_empty", walk_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_tlb_req_queue.md
# l2_tlb_req_queue

Responder end of the TlbL2IO request channel. It accepts one-cycle, non-backpressured miss requests from the first-level TLBs (through their repeaters), buffers them in an in-order miss queue, and serializes them onto a single page-table-walker port. It returns exactly one registered response per request, echoing the request's info. A request that finds the queue full is refused with an error response, so the LSU replays it.

## Interface
Parameters:
- VADDR_SIZE, 39, virtual address width
- TLB_OFFSET, 12, page offset bits
- IDX_WIDTH, 5, width of info.idx
- WPN_WIDTH, 2, page-level field width
- DEPTH, 4, miss-queue entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  discard all outstanding requests
- req  in  1  request pulse; no ready signal, always sampled
- req_addr  in  VADDR_SIZE  faulting virtual address
- req_source  in  2  info.source (01 load, 10 store, 11 amo, 00 ifetch)
- req_idx  in  IDX_WIDTH  info.idx
- walk_req  out  1  walk request valid
- walk_vaddr  out  VADDR_SIZE  walk address
- walk_ready  in  1  walker accepts when walk_req & walk_ready
- walk_resp_valid  in  1  walk result valid, one cycle
- walk_entry  in  PTE_T  leaf PTE
- walk_wpn  in  WPN_WIDTH  leaf level
- walk_error  in  1  access fault during walk
- walk_exception  in  1  page fault
- dataValid  out  1  response pulse
- info_o_source / info_o_idx  out  2 / IDX_WIDTH  echoed info
- entry  out  PTE_T  returned PTE
- wpn  out  WPN_WIDTH  returned level
- waddr  out  VADDR_SIZE  echoed request address
- error  out  1  walk access fault or queue-full refusal
- exception  out  1  page fault

## Operation
- The queue is a circular FIFO: head and tail pointers, each log2(DEPTH) bits wide, plus a count register 0..DEPTH. Each entry stores {addr, source, idx}.
- Accept: if req & ~flush & count<DEPTH, where count is sampled at the start of the cycle, write the entry at the tail and increment the tail.
- Refuse: if req & ~flush & count==DEPTH, load the single reject register rej_v with {addr, source, idx}.
- Walker FSM has two states.
  - IDLE: walk_req = (count≠0) & ~flush, walk_vaddr = head.addr. On the handshake, go to WALK.
  - WALK: walk_req=0. On walk_resp_valid, go to IDLE, pop the head (head++, count--) and issue the response.
- Response port:
  - A walk response has priority. It presents the head entry's info and addr plus walk_entry, walk_wpn, walk_error and walk_exception.
  - Otherwise, if rej_v, respond with error=1, exception=0, entry=0, then clear rej_v.
  - rej_v may load and drain in the same cycle.
- Invariant (assert): a refusal never arrives while rej_v is set and not draining. This holds because a walk response frees a slot, and the walker never responds in consecutive cycles.
- Flush:
  - Set tail to head+1 if in WALK, otherwise to head. Set count to the WALK bit. Clear rej_v.
  - If in WALK, set the killed flag. The walk result is still consumed and popped, but dataValid stays 0 and killed is cleared.
  - A req in the same cycle as flush is dropped.
- Count arithmetic: accept and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.

## Timing
- Reset values: all outputs 0. FSM is IDLE, count=0, rej_v=0, killed=0.
- A request accepted at cycle t has walk_req high at t+1 at the earliest.
- walk_resp_valid at cycle u produces dataValid at u+1, because all response outputs are registered.
- A refusal at cycle t produces dataValid at t+1. If a walk response is also presented at t+1, the refusal is delayed to t+2.
- dataValid is a one-cycle pulse; exactly one per accepted, unflushed request.
- walk_req is combinational from state and count, and is held until walk_ready.
- Reset mid-walk returns to IDLE; any later walk_resp_valid is ignored while IDLE.

## Structure
- Shared package mmu_pkg holds:
  - PTE_T
  - the tlb_info_t struct {source, idx}
  - constants SRC_LOAD/STORE/AMO/IFETCH
  - the queue-entry struct
- Sub-module: l2_tlb_miss_fifo, the circular storage with head, tail and count, exposing push, pop, flush_keep_head, full and head data.
- The top level holds the FSM, the killed flag, the reject register and the response register.

## Test plan
- Single load miss (addr 0x8000_1234, source 01, idx 5) with walker ready and response 3 cycles after issue -> walk_req at t+1 with walk_vaddr 0x8000_1234; dataValid 1 cycle after walk_resp_valid with info 01/5, waddr echoed and error=0.
- Fill with DEPTH+1 back-to-back requests while the walker is stalled (walk_ready=0) -> 5th request gets dataValid at t+1 with error=1 and its idx; the first four are walked in order 0..3.
- Walk response and refusal in the same cycle -> walk response at u+1, refusal at u+2, and the next request is accepted into the freed slot.
- Flush while in WALK with 3 entries queued -> no dataValid for the killed walk; count reads 0 after the pop; a new request after the flush is walked next.
- walk_exception=1 response -> dataValid with exception=1 and error=0; pointer wrap verified over 2×DEPTH sequential misses.
- Async rst asserted during WALK -> all outputs go to 0 immediately; a stray walk_resp_valid after reset produces no dataValid.
